// File: rtl/return_stack_pkg.sv
// Shared core constants for the PC / return-stack pair.
// Holds the program-address and opcode widths plus the opcode encodings
// that both the PC and the return stack decode from the common opcode bus.
package return_stack_pkg;

    localparam int PC_WIDTH     = 8;
    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] JMP     = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] IF0JUMP = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] CALL    = 4'hA;
    localparam logic [OPCODE_WIDTH-1:0] RET     = 4'hB;
    localparam logic [OPCODE_WIDTH-1:0] IF1JUMP = 4'hC;
    localparam logic [OPCODE_WIDTH-1:0] RST     = 4'hF;

endpackage

// File: rtl/return_stack_mem.sv
// Return-address storage: DEPTH x WIDTH register file.
// Ports:
//   clock    - rising-edge write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (asynchronous read)
//   rdata_o  - read data
// Storage has no reset; only the valid-entry count in the parent decides
// which words are meaningful.
module return_stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Call/return address stack beside the PC.
// Decodes the shared opcode bus: CALL pushes called_from+1, RET pops,
// RST clears depth and flags. return_to is the current top of stack
// (0 when empty), read combinationally so the PC can load it on the pop edge.
// Ports:
//   clock, reset_n - system clock, async active-low reset
//   reset_code     - opcode bus (RST while reset button held)
//   called_from    - PC of the executing instruction
//   return_to      - top-of-stack address
//   depth          - number of valid entries, 0..DEPTH
//   empty, full    - depth == 0, depth == DEPTH
//   overflow       - sticky, CALL seen while full
//   underflow      - sticky, RET seen while empty
module return_stack
    import return_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = $clog2(DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [OPCODE_WIDTH-1:0] reset_code,
    input  logic [PC_WIDTH-1:0]     called_from,
    output logic [PC_WIDTH-1:0]     return_to,
    output logic [DW-1:0]           depth,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    underflow
);

    logic [DW-1:0]       depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                is_call, is_ret, is_rst;
    logic                push, pop;
    logic                we;
    logic [AW-1:0]       raddr;
    logic [PC_WIDTH-1:0] rdata;

    assign is_call = (reset_code == CALL);
    assign is_ret  = (reset_code == RET);
    assign is_rst  = (reset_code == RST);

    assign empty = (depth_q == '0);
    assign full  = (depth_q == DW'(DEPTH));

    assign push = is_call && !full;
    assign pop  = is_ret && !empty;

    // Gating with reset_n keeps a push from landing in storage on an edge
    // that coincides with an asserted async reset.
    assign we = push && reset_n;

    // When full the low bits of depth wrap to 0, so minus one still lands
    // on the top entry.
    assign raddr = depth_q[AW-1:0] - AW'(1);

    return_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PC_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .we_i    (we),
        .waddr_i (depth_q[AW-1:0]),
        .wdata_i (called_from + PC_WIDTH'(1)),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (is_rst) begin
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (is_call) begin
            if (full) ovf_d = 1'b1;
            else      depth_d = depth_q + DW'(1);
        end else if (is_ret) begin
            if (empty) unf_d = 1'b1;
            else       depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign return_to = empty ? '0 : rdata;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    logic unused_pop;
    assign unused_pop = pop;

endmodule

// File: tb/tb_return_stack.sv
module tb_return_stack;
    import return_stack_pkg::*;

    localparam int DEPTH = 16;

    logic                    clock;
    logic                    reset_n;
    logic [OPCODE_WIDTH-1:0] reset_code;
    logic [PC_WIDTH-1:0]     called_from;
    logic [PC_WIDTH-1:0]     return_to;
    logic [4:0]              depth;
    logic                    empty, full, overflow, underflow;

    return_stack #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .reset_code  (reset_code),
        .called_from (called_from),
        .return_to   (return_to),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] ret;
        logic [4:0] dep;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [DEPTH];
    int         m_depth;
    logic       m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_top();
        return (m_depth == 0) ? 8'h00 : m_mem[m_depth-1];
    endfunction

    function automatic exp_t m_snapshot();
        exp_t e;
        e.ret = m_top();
        e.dep = 5'(m_depth);
        e.emp = (m_depth == 0);
        e.ful = (m_depth == DEPTH);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".return_to"}, 32'(return_to), 32'(e.ret));
        chk({tag, ".depth"},     32'(depth),     32'(e.dep));
        chk({tag, ".empty"},     32'(empty),     32'(e.emp));
        chk({tag, ".full"},      32'(full),      32'(e.ful));
        chk({tag, ".overflow"},  32'(overflow),  32'(e.ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(e.unf));
    endtask

    // Called at a negedge: drive the opcode, check the same-cycle top value,
    // advance the model, queue the post-edge expectation, then compare it
    // at the following negedge.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] pc);
        exp_t e;
        reset_code  = op;
        called_from = pc;
        #1;
        chk({tag, ".pre_top"}, 32'(return_to), 32'(m_top()));
        if (op == RST) begin
            m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (op == CALL) begin
            if (m_depth == DEPTH) m_ovf = 1'b1;
            else begin
                m_mem[m_depth] = pc + 8'h01;
                m_depth++;
            end
        end else if (op == RET) begin
            if (m_depth == 0) m_unf = 1'b1;
            else m_depth--;
        end
        sb.push_back(m_snapshot());
        @(negedge clock);
        reset_code = JMP;
        #1;
        e = sb.pop_front();
        check_outputs(tag, e);
        @(negedge clock);
    endtask

    initial begin
        reset_n     = 1'b0;
        reset_code  = JMP;
        called_from = 8'h00;
        m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

        @(negedge clock);
        check_outputs("reset", m_snapshot());
        reset_n = 1'b1;
        @(negedge clock);

        // 1: single call/return
        do_op("t1_call", CALL, 8'h10);
        chk("t1_top", 32'(return_to), 32'h11);
        do_op("t1_ret", RET, 8'h00);
        chk("t1_empty", 32'(empty), 32'h1);

        // 2: nested calls, LIFO order
        do_op("t2_c1", CALL, 8'h01);
        do_op("t2_c2", CALL, 8'h05);
        do_op("t2_c3", CALL, 8'h09);
        do_op("t2_jmp", JMP, 8'h33);
        do_op("t2_if0", IF0JUMP, 8'h34);
        chk("t2_top3", 32'(return_to), 32'h0A);
        do_op("t2_r1", RET, 8'h00);
        chk("t2_top2", 32'(return_to), 32'h06);
        do_op("t2_r2", RET, 8'h00);
        chk("t2_top1", 32'(return_to), 32'h02);
        do_op("t2_r3", RET, 8'h00);

        // 3: fill, then overflow
        for (int i = 0; i < DEPTH; i++) do_op("t3_fill", CALL, 8'(i));
        chk("t3_full", 32'(full), 32'h1);
        do_op("t3_ovf", CALL, 8'h40);
        chk("t3_ovf_flag", 32'(overflow), 32'h1);
        chk("t3_top_kept", 32'(return_to), 32'h10);

        // 4: underflow is sticky across a later call
        do_op("t4_rst", RST, 8'h00);
        do_op("t4_unf", RET, 8'h00);
        chk("t4_unf_flag", 32'(underflow), 32'h1);
        do_op("t4_call", CALL, 8'h20);
        chk("t4_top", 32'(return_to), 32'h21);
        do_op("t4_if1", IF1JUMP, 8'h55);

        // 5: depth 3 with both flags, then RST
        for (int i = 0; i < DEPTH - 1; i++) do_op("t5_fill", CALL, 8'(8'h80 + i));
        do_op("t5_ovf", CALL, 8'hEE);
        for (int i = 0; i < DEPTH - 3; i++) do_op("t5_pop", RET, 8'h00);
        chk("t5_depth3", 32'(depth), 32'd3);
        do_op("t5_rst", RST, 8'h00);
        chk("t5_clear", 32'({depth, overflow, underflow}), 32'h0);

        // 6: async reset between edges, then address wrap
        do_op("t6_c1", CALL, 8'h11);
        do_op("t6_c2", CALL, 8'h22);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_depth", 32'(depth), 32'd0);
        chk("t6_async_empty", 32'(empty), 32'h1);
        m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_op("t6_wrap", CALL, 8'hFF);
        chk("t6_wrap_top", 32'(return_to), 32'h00);
        chk("t6_wrap_depth", 32'(depth), 32'd1);

        // Async reset landing on a CALL edge must not push.
        reset_code  = CALL;
        called_from = 8'h70;
        @(posedge clock);
        reset_n = 1'b0;
        #1;
        reset_code = JMP;
        m_depth = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_op("t6_after", JMP, 8'h00);
        chk("t6_after_depth", 32'(depth), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
